// File: rtl/difficulty_select_ctrl.sv
// difficulty_select_ctrl: debounces and arbitrates BTNL/BTNC/BTNR into a difficulty code
// (L=1, C=2, R=3, priority L > C > R) and holds each accepted selection with a valid/ack
// handshake until the CPU consumes it.
// Optional feature macro: DIFF_STICKY_EN -- when defined, difficulty keeps the last accepted
// code after ack; otherwise it clears to 0 on the ack edge.
module difficulty_select_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic        clock,
    input  logic        anti_reset,
    input  logic        BTNL,
    input  logic        BTNC,
    input  logic        BTNR,
    input  logic        difficulty_ack,
    output logic [31:0] difficulty,
    output logic        difficulty_valid,
    output logic [7:0]  select_count,
    output logic [1:0]  ctrl_state
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StHold    = 2'd2,
        StRelease = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cand_q, cand_d;
    logic [2:0]       sync1_q, s_q;
    logic [1:0]       code;
    logic             accept, consume;
    logic [1:0]       diff_q, diff_d;
    logic             valid_q, valid_d;
    logic [7:0]       count_q, count_d;

    // Two-flop synchronizer; bit 0 = L, bit 1 = C, bit 2 = R
    always_ff @(posedge clock or negedge anti_reset) begin
        if (!anti_reset) begin
            sync1_q <= 3'b000;
            s_q     <= 3'b000;
        end else begin
            sync1_q <= {BTNR, BTNC, BTNL};
            s_q     <= sync1_q;
        end
    end

    // Fixed-priority encoder of the synchronized buttons
    always_comb begin
        code = 2'd0;
        if (s_q[0])      code = 2'd1;
        else if (s_q[1]) code = 2'd2;
        else if (s_q[2]) code = 2'd3;
    end

    assign accept  = (state_q == StArmed) && (code == cand_q) && (cnt_q == CntLast);
    assign consume = (state_q == StHold) && difficulty_ack;

    // State register together with debounce counter and candidate
    always_ff @(posedge clock or negedge anti_reset) begin
        if (!anti_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cand_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    // Next-state logic: debounce press in ARMED, debounce full release in RELEASE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (code != 2'd0) begin
                    cand_d  = code;
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (code == cand_q) begin
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        state_d = StHold;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // Candidate aborted; re-arm only from IDLE on a later cycle
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (difficulty_ack) begin
                    cnt_d   = '0;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (s_q == 3'b000) begin
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
        endcase
    end

    // Output next-state: latch the code on acceptance, drop valid on consume
    always_comb begin
        diff_d  = diff_q;
        valid_d = valid_q;
        count_d = count_q;
        if (accept) begin
            diff_d  = cand_q;
            valid_d = 1'b1;
            count_d = count_q + 8'd1;
        end
        if (consume) begin
            valid_d = 1'b0;
`ifdef DIFF_STICKY_EN
            diff_d  = diff_q;
`else
            diff_d  = 2'd0;
`endif
        end
    end

    // Registered outputs
    always_ff @(posedge clock or negedge anti_reset) begin
        if (!anti_reset) begin
            diff_q  <= 2'd0;
            valid_q <= 1'b0;
            count_q <= 8'd0;
        end else begin
            diff_q  <= diff_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign difficulty       = {30'd0, diff_q};
    assign difficulty_valid = valid_q;
    assign select_count     = count_q;
    assign ctrl_state       = state_q;

endmodule

// File: doc/difficulty_select_ctrl.md
# difficulty_select_ctrl

Debounces and arbitrates the three difficulty buttons (BTNL, BTNC, BTNR) into one difficulty code for the processor's `difficulty_in` input. Each accepted selection is held with a valid/ack handshake so the game loop cannot miss it. It runs on the 50 MHz processor `clock` and sits between the board buttons and the CPU.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles needed to accept a press or a release. This is 10 ms at 50 MHz. Must be ≥ 2.
- `CNT_W`, default 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clock` — in — 1 — processor clock, rising edge.
- `anti_reset` — in — 1 — asynchronous, active-low reset.
- `BTNL` — in — 1 — raw, asynchronous button input; selects code 1.
- `BTNC` — in — 1 — raw, asynchronous button input; selects code 2.
- `BTNR` — in — 1 — raw, asynchronous button input; selects code 3.
- `difficulty_ack` — in — 1 — CPU consume strobe; sampled only in HOLD.
- `difficulty` — out — 32 — selected code, zero-extended; bits [31:2] are always 0.
- `difficulty_valid` — out — 1 — a new selection is pending.
- `select_count` — out — 8 — number of accepted selections; wraps 255→0.
- `ctrl_state` — out — 2 — FSM state for debug: IDLE=0, ARMED=1, HOLD=2, RELEASE=3.

## Operation
- **Synchronizer:** each button passes through a 2-flop synchronizer, giving `s[2:0]`.
- **Priority encoder:** `code` = 1 if L, else 2 if C, else 3 if R, else 0. Fixed priority is L > C > R.
- **IDLE:** `cnt`=0.
  - If `code`≠0: `cand`←`code`, go to ARMED.
- **ARMED:**
  - If `code`==`cand` and `cnt`==DEBOUNCE_CYCLES−1: `difficulty`←`cand`, `difficulty_valid`←1, `select_count`++, go to HOLD.
  - If `code`==`cand` otherwise: `cnt`++.
  - If `code`≠`cand` (including 0): `cnt`←0, go to IDLE. No re-arm occurs in that same cycle.
- **HOLD:** `difficulty_valid`=1. All button activity is ignored.
  - On `difficulty_ack`=1: `difficulty_valid`←0, `cnt`←0, go to RELEASE. `difficulty` is handled per Configuration.
- **RELEASE:**
  - If all of `s` are 0: `cnt`++. When `cnt`==DEBOUNCE_CYCLES−1, go to IDLE.
  - If any bit of `s` is 1: `cnt`←0.
  - A held button therefore never produces a second selection.
- **Simultaneous presses:** the higher-priority code wins at IDLE.
  - A press that changes `code` during ARMED aborts the candidate.
- **Reset:** asserting `anti_reset` low at any time, including mid-HOLD, immediately clears all of the following to 0:
  - `difficulty`, `difficulty_valid`, `select_count`
  - state (forced to IDLE), `cnt`, `cand`, synchronizer flops

## Timing
- Let the raw button go high before rising edge k.
  - `s` is high after edge k+1.
  - ARMED is entered at edge k+2.
  - `difficulty_valid` rises at edge k+2+DEBOUNCE_CYCLES.
- `difficulty_ack` is first sampled at the edge after `difficulty_valid` rises.
  - Ack in the same edge as the valid rise is ignored.
  - Ack outside HOLD is ignored.
- `difficulty_valid` falls on the edge that samples ack. The minimum pulse is 1 cycle.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Configuration
- `DIFF_STICKY_EN` defined:
  - `difficulty` keeps the last accepted code after ack, until the next acceptance or reset.
- `DIFF_STICKY_EN` undefined:
  - `difficulty` clears to 0 on the ack edge.
  - The CPU therefore sees a nonzero code only while a selection is pending.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
1. **Single press:** BTNC high at edge 10, ack at edge 20.
   - Required: `difficulty_valid` rises at edge 16 with `difficulty`=2 and `select_count`=1.
   - Required: valid falls at edge 20.
2. **Bounce:** BTNR toggles high 2 cycles, low 1 cycle, repeated 3 times, then stays high.
   - Required: exactly one acceptance, `difficulty`=3, `select_count`=1.
3. **Simultaneous press and hold:** BTNL and BTNR high together, then held through ack.
   - Required: `difficulty`=1.
   - Required: no second valid while held.
   - Required: after release for ≥6 cycles and a re-press, a second acceptance occurs.
4. **Ack handling:** ack held high constantly.
   - Required: valid lasts exactly 1 cycle per press.
   - Required: ack while in IDLE has no effect.
5. **Reset mid-operation:** reset asserted during HOLD.
   - Required: all outputs are 0 and `ctrl_state`=0, asynchronously, before the next edge.
6. **Wrap and configuration:** 256 presses.
   - Required: `select_count` wraps to 0.
   - Required with `DIFF_STICKY_EN`: `difficulty` stays 2 after ack.
   - Required without `DIFF_STICKY_EN`: `difficulty` reads 0 after ack.
